// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit.
// Optional jump support is selected with the MC_CTRL_JUMP_EN macro.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_JUMP      = 4'd12,
        S_HALT      = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // States that stall on the memory handshake.
    function automatic logic is_wait(state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode: state plus mem_ready to datapath enables.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        instr_done,
    output logic        halted
);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALU_ADD;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        halted        = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:    alu_src_b = 2'b11;
            S_MEM_ADDR, S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            S_HALT:      halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: FSM, memory timeout trap and retire counter.
// Define MC_CTRL_JUMP_EN to dispatch opcode 2 to the JUMP state.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic [3:0]          state,
    output logic                illegal_op,
    output logic                instr_done,
    output logic                halted,
    output logic [RETIRE_W-1:0] retired_cnt
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t          cur_state;
    state_t          nxt_state;
    logic            is_store;
    logic [TW-1:0]   tmo_cnt;
    logic            tmo_hit;

    assign state = cur_state;

    assign tmo_hit = (MEM_TIMEOUT != 0) && is_wait(cur_state) && !mem_ready
                     && (tmo_cnt == TW'(MEM_TIMEOUT - 1));

    always_comb begin
        nxt_state  = cur_state;
        illegal_op = 1'b0;
        case (cur_state)
            S_RESET:     nxt_state = S_FETCH;
            S_FETCH:     if (mem_ready) nxt_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt_state = S_MEM_ADDR;
                    OP_RTYPE:     nxt_state = S_EXECUTE;
                    OP_BEQ:       nxt_state = S_BRANCH;
                    OP_ADDI:      nxt_state = S_ADDI_EXEC;
`ifdef MC_CTRL_JUMP_EN
                    OP_J:         nxt_state = S_JUMP;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        nxt_state  = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR:  nxt_state = is_store ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) nxt_state = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) nxt_state = S_FETCH;
            S_EXECUTE:   nxt_state = S_R_WB;
            S_ADDI_EXEC: nxt_state = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_ADDI_WB, S_JUMP: nxt_state = S_FETCH;
            S_HALT:      nxt_state = S_HALT;
            default:     nxt_state = S_RESET;
        endcase
        if (tmo_hit) nxt_state = S_HALT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state   <= S_RESET;
            is_store    <= 1'b0;
            tmo_cnt     <= '0;
            retired_cnt <= '0;
        end else begin
            cur_state <= nxt_state;
            // Opcode is only valid in DECODE; remember load vs store for MEM_ADDR.
            if (cur_state == S_DECODE) is_store <= (opcode == OP_SW);
            if (nxt_state != cur_state)
                tmo_cnt <= '0;
            else if (is_wait(cur_state) && !mem_ready)
                tmo_cnt <= tmo_cnt + TW'(1);
            if (instr_done) retired_cnt <= retired_cnt + RETIRE_W'(1);
        end
    end

    mc_ctrl_decode u_decode (
        .state         (cur_state),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .instr_done    (instr_done),
        .halted        (halted)
    );

endmodule
